// File: rtl/hero_write_arb_pkg.sv
// hero_write_arb_pkg: shared types and constants for the hero write arbiter
package hero_write_arb_pkg;
  localparam int HERO_WIDTH = 36;
  localparam int HERO_ARB_TXN_COUNT_WIDTH = 16;
  typedef enum logic [1:0] {
    CYCLE_TYPE_IDLE  = 2'd0,
    CYCLE_TYPE_VALID = 2'd1,
    CYCLE_TYPE_DONE  = 2'd2,
    CYCLE_TYPE_RSVD  = 2'd3
  } cycle_type_e;
  typedef enum logic {ARB_OPEN = 1'b0, ARB_LOCKED = 1'b1} hero_arb_state_e;
  typedef struct packed {
    cycle_type_e             cycle_type;
    logic [HERO_WIDTH-1:0]   wdat;
  } hero_arb_beat_t;
endpackage

// File: rtl/hero_write_arb_fifo.sv
// hero_write_arb_fifo: synchronous FIFO, registered write, combinational head read
module hero_write_arb_fifo
  import hero_write_arb_pkg::*;
#(
  parameter int WIDTH = HERO_WIDTH + 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      r_wp, r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  // extra pointer MSB separates full from empty when the index bits match
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_data  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push && !o_full) r_wp <= r_wp + 1'b1;
      if (i_pop && !o_empty) r_rp <= r_rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (i_push && !o_full) r_mem[r_wp[AW-1:0]] <= i_data;
endmodule

// File: rtl/hero_write_arb.sv
// hero_write_arb: per-channel FIFOs merged onto one hero write bus, round-robin per transaction
// Optional per-channel DONE counters with HERO_WRITE_ARB_STATS_EN.
module hero_write_arb
  import hero_write_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = HERO_WIDTH,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(NUM_CH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CH-1:0]                    in_valid,
  output logic [NUM_CH-1:0]                    in_ready,
  input  logic [NUM_CH-1:0][1:0]               in_cycle_type,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    in_wdat,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [1:0]                           out_cycle_type,
  output logic [DATA_WIDTH-1:0]                out_wdat,
  output logic [CW-1:0]                        out_ch,
`ifdef HERO_WRITE_ARB_STATS_EN
  input  logic                                 stats_clr,
  output logic [NUM_CH-1:0][HERO_ARB_TXN_COUNT_WIDTH-1:0] txn_count,
`endif
  output logic [NUM_CH-1:0]                    err_idle
);
  logic [NUM_CH-1:0]                    w_empty, w_full, w_push, w_pop, w_idle;
  logic [NUM_CH-1:0][DATA_WIDTH+1:0]    w_head;
  logic [1:0]                           w_hct;
  logic [DATA_WIDTH-1:0]                w_hdat;
  logic [CW-1:0]                        w_pick, w_idx, w_sel;
  logic [CW-1:0]                        r_rr, r_lock_ch, r_hold_ch;
  logic                                 r_hold, w_acc, w_done;
  hero_arb_state_e                      r_state;
  logic [NUM_CH-1:0]                    r_err_idle;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign in_ready[i] = !rst && !w_full[i];
    assign w_push[i]   = in_valid[i] && in_ready[i] &&
                         (in_cycle_type[i] == CYCLE_TYPE_VALID || in_cycle_type[i] == CYCLE_TYPE_DONE);
    assign w_idle[i]   = in_valid[i] && in_ready[i] && in_cycle_type[i] == CYCLE_TYPE_IDLE;
    assign w_pop[i]    = w_acc && w_sel == CW'(i);
    hero_write_arb_fifo #(.WIDTH(DATA_WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .i_push(w_push[i]), .i_data({in_cycle_type[i], in_wdat[i]}),
      .i_pop(w_pop[i]), .o_data(w_head[i]),
      .o_empty(w_empty[i]), .o_full(w_full[i])
    );
  end
  // descending scan so the nearest non-empty channel at or after r_rr wins
  always_comb begin
    w_pick = r_rr;
    w_idx  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = CW'((int'(r_rr) + k) % NUM_CH);
      if (!w_empty[w_idx]) w_pick = w_idx;
    end
  end
  // r_hold pins an unaccepted beat so a newly filled channel cannot steal the bus
  assign w_sel            = (r_state == ARB_LOCKED) ? r_lock_ch : r_hold ? r_hold_ch : w_pick;
  assign {w_hct, w_hdat}  = w_head[w_sel];
  assign out_valid        = !w_empty[w_sel];
  assign out_cycle_type   = out_valid ? w_hct : CYCLE_TYPE_IDLE;
  assign out_wdat         = out_valid ? w_hdat : '0;
  assign out_ch           = out_valid ? w_sel : '0;
  assign w_acc            = out_valid && out_ready;
  assign w_done           = w_acc && w_hct == CYCLE_TYPE_DONE;
  assign err_idle         = r_err_idle;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_OPEN;
      r_rr       <= '0;
      r_lock_ch  <= '0;
      r_hold     <= 1'b0;
      r_hold_ch  <= '0;
      r_err_idle <= '0;
    end else begin
      r_hold     <= out_valid && !out_ready && r_state == ARB_OPEN;
      r_hold_ch  <= w_sel;
      r_err_idle <= r_err_idle | w_idle;
      if (w_acc && r_state == ARB_OPEN && w_hct == CYCLE_TYPE_VALID) begin
        r_state   <= ARB_LOCKED;
        r_lock_ch <= w_sel;
      end
      if (w_done) begin
        r_state <= ARB_OPEN;
        r_rr    <= (w_sel == CW'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;
      end
    end
  end
`ifdef HERO_WRITE_ARB_STATS_EN
  logic [NUM_CH-1:0][HERO_ARB_TXN_COUNT_WIDTH-1:0] r_txn;
  always_ff @(posedge clk) begin
    if (rst || stats_clr) r_txn <= '0;
    else if (w_done && r_txn[w_sel] != '1) r_txn[w_sel] <= r_txn[w_sel] + 1'b1;
  end
  assign txn_count = r_txn;
`endif
endmodule

// File: tb/tb_hero_write_arb.sv
// tb_hero_write_arb: directed self-checking bench for hero_write_arb
module tb_hero_write_arb;
  import hero_write_arb_pkg::*;
  localparam int N = 4, DW = 36;
  logic clk = 1'b0, rst, out_valid, out_ready;
  logic [N-1:0] in_valid, in_ready, err_idle;
  logic [N-1:0][1:0] in_cycle_type;
  logic [N-1:0][DW-1:0] in_wdat;
  logic [1:0] out_cycle_type, out_ch;
  logic [DW-1:0] out_wdat;
`ifdef HERO_WRITE_ARB_STATS_EN
  logic stats_clr;
  logic [N-1:0][15:0] txn_count;
`endif
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  hero_write_arb #(.NUM_CH(N), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cycle_type(in_cycle_type), .in_wdat(in_wdat),
    .out_valid(out_valid), .out_ready(out_ready), .out_cycle_type(out_cycle_type),
    .out_wdat(out_wdat), .out_ch(out_ch),
`ifdef HERO_WRITE_ARB_STATS_EN
    .stats_clr(stats_clr), .txn_count(txn_count),
`endif
    .err_idle(err_idle)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [1:0] ch, input logic [1:0] ct, input logic [DW-1:0] d);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".ch"}, 64'(out_ch), 64'(ch));
    check({tag, ".ct"}, 64'(out_cycle_type), 64'(ct));
    check({tag, ".wdat"}, 64'(out_wdat), 64'(d));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input int ch, input logic [1:0] ct, input logic [DW-1:0] d);
    in_valid[ch] = 1'b1;
    in_cycle_type[ch] = ct;
    in_wdat[ch] = d;
  endtask
  task automatic clr_in();
    in_valid = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  localparam logic [1:0] V = CYCLE_TYPE_VALID, D = CYCLE_TYPE_DONE, I = CYCLE_TYPE_IDLE;
  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_cycle_type = '0;
    in_wdat = '0;
    out_ready = 1'b0;
`ifdef HERO_WRITE_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    tick();
    check("rst.in_ready", 64'(in_ready), 64'h0);
    check("rst.out_valid", 64'(out_valid), 64'h0);
    check("rst.out_wdat", 64'(out_wdat), 64'h0);
    check("rst.out_ct", 64'(out_cycle_type), 64'h0);
    check("rst.out_ch", 64'(out_ch), 64'h0);
    check("rst.err_idle", 64'(err_idle), 64'h0);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", 64'(in_ready), 64'hF);
    // single channel VALID,VALID,DONE back to back
    out_ready = 1'b1;
    drv(0, V, 36'd1); tick(); chk_out("t1.b0", 2'd0, V, 36'd1);
    drv(0, V, 36'd2); tick(); chk_out("t1.b1", 2'd0, V, 36'd2);
    drv(0, D, 36'd3); tick(); chk_out("t1.b2", 2'd0, D, 36'd3);
    clr_in(); tick();
    check("t1.idle", 64'(out_valid), 64'h0);
    // two channels loaded in the same cycles, no interleave
    do_reset();
    for (int b = 0; b < 3; b++) begin
      drv(0, (b == 2) ? D : V, DW'(10 + b));
      drv(2, (b == 2) ? D : V, DW'(20 + b));
      tick();
    end
    clr_in();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk_out($sformatf("t2.b%0d", k), (k < 3) ? 2'd0 : 2'd2, (k % 3 == 2) ? D : V,
              (k < 3) ? DW'(10 + k) : DW'(17 + k));
      tick();
    end
    check("t2.drained", 64'(out_valid), 64'h0);
    out_ready = 1'b0;
    drv(0, D, 36'd7); drv(3, D, 36'd8); tick(); clr_in();
    chk_out("t2.rr3", 2'd3, D, 36'd8);
    out_ready = 1'b1;
    tick(); chk_out("t2.rr0", 2'd0, D, 36'd7);
    tick(); check("t2.end", 64'(out_valid), 64'h0);
    // lock held on ch1 while its FIFO is empty and ch3 waits
    do_reset();
    out_ready = 1'b1;
    drv(1, V, 36'h31); drv(3, V, 36'h41); tick(); clr_in();
    chk_out("t3.lock", 2'd1, V, 36'h31);
    drv(3, D, 36'h42); tick(); clr_in();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t3.gap%0d", c), 64'(out_valid), 64'h0);
      if (c < 4) tick();
    end
    drv(1, D, 36'h32); tick(); clr_in();
    chk_out("t3.done1", 2'd1, D, 36'h32);
    tick(); chk_out("t3.ch3a", 2'd3, V, 36'h41);
    tick(); chk_out("t3.ch3b", 2'd3, D, 36'h42);
    tick(); check("t3.end", 64'(out_valid), 64'h0);
    // backpressure fills ch0 FIFO
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(0, V, DW'(50 + k)); tick();
      if (k == 2) check("t4.not_full", 64'(in_ready[0]), 64'h1);
    end
    check("t4.full", 64'(in_ready[0]), 64'h0);
    chk_out("t4.hold", 2'd0, V, 36'd50);
    drv(0, V, 36'd54); out_ready = 1'b1; tick();
    check("t4.ready_back", 64'(in_ready[0]), 64'h1);
    chk_out("t4.b1", 2'd0, V, 36'd51);
    tick(); chk_out("t4.b2", 2'd0, V, 36'd52);
    drv(0, D, 36'd55); tick(); clr_in();
    chk_out("t4.b3", 2'd0, V, 36'd53);
    tick(); chk_out("t4.b4", 2'd0, V, 36'd54);
    tick(); chk_out("t4.b5", 2'd0, D, 36'd55);
    tick(); check("t4.end", 64'(out_valid), 64'h0);
    // IDLE beat is dropped and flagged
    do_reset();
    out_ready = 1'b1;
    drv(2, I, 36'h99); tick(); clr_in();
    check("t5.err", 64'(err_idle), 64'h4);
    check("t5.dropped", 64'(out_valid), 64'h0);
    tick(); tick();
    check("t5.sticky", 64'(err_idle), 64'h4);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5.cleared", 64'(err_idle), 64'h0);
`ifdef HERO_WRITE_ARB_STATS_EN
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      drv(1, D, DW'(t)); tick(); clr_in(); tick();
    end
    check("t6.cnt1", 64'(txn_count[1]), 64'd3);
    check("t6.cnt0", 64'(txn_count[0]), 64'd0);
    drv(1, D, 36'd9); tick(); clr_in();
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    check("t6.clr", 64'(txn_count[1]), 64'd0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
